// File: rtl/dram_burst_model_if.sv
// L2-side command/data bus of the DRAM burst model.
interface dram_burst_model_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic              L2cmd_valid;
   logic              L2cmd_ready;
   logic              L2cmd;
   logic [ADDR_W-1:0] L2addr;
   logic [DATA_W-1:0] L2wdata;
   logic              L2wvalid;
   logic [DATA_W-1:0] L2data;
   logic              strobe;
   logic              busy;

   modport master (
      output L2cmd_valid, L2cmd, L2addr, L2wdata, L2wvalid,
      input  L2cmd_ready, L2data, strobe, busy
   );

   modport slave (
      input  L2cmd_valid, L2cmd, L2addr, L2wdata, L2wvalid,
      output L2cmd_ready, L2data, strobe, busy
   );
endinterface

// File: rtl/dram_burst_model.sv
// DRAM model with real storage serving L2 line fills and writebacks as fixed-length bursts.
//
// state  | meaning
// IDLE   | ready for a command
// RLAT   | read access latency countdown; emits beat 0 on expiry
// RBURST | one read beat per cycle until the burst is done
// WDATA  | storing write beats on L2wvalid, gaps allowed
// WLAT   | write latency countdown, then one done strobe
module dram_burst_model #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 32,
   parameter int MEM_AW    = 12,
   parameter int BURST_LEN = 8,
   parameter int READ_LAT  = 4,
   parameter int WRITE_LAT = 2,
   parameter int WRAP      = 0
) (
   input logic               clk,
   input logic               rst,
   dram_burst_model_if.slave l2
);
   localparam int B       = $clog2(DATA_W / 8);
   localparam int L       = $clog2(BURST_LEN);
   localparam int DEPTH   = 1 << MEM_AW;
   localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int LAT_W   = $clog2(LAT_MAX + 1);
   localparam logic [MEM_AW-1:0] LMASK     = MEM_AW'(BURST_LEN - 1);
   localparam logic [L:0]        BEAT_END  = (L + 1)'(BURST_LEN);
   localparam logic [L-1:0]      BEAT_LAST = L'(BURST_LEN - 1);

   typedef enum logic [2:0] {IDLE, RLAT, RBURST, WDATA, WLAT} state_t;

   state_t            state;
   logic [MEM_AW-1:0] start_idx;
   logic [L:0]        beat;
   logic [LAT_W-1:0]  lat_cnt;
   logic              strobe_q;
   logic [DATA_W-1:0] data_q;
   logic [MEM_AW-1:0] beat_off;
   logic [MEM_AW-1:0] cur_idx;
   logic [DATA_W-1:0] cur_rdata;

   // Storage holds the XOR against each word's own byte address, so an all-zero
   // power-up image reads back as the address-pattern initial contents.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   function automatic logic [DATA_W-1:0] addr_pattern(input logic [MEM_AW-1:0] idx);
      return DATA_W'(idx) << B;
   endfunction

   assign beat_off = MEM_AW'(beat[L-1:0]);

   always_comb begin
      cur_idx = start_idx + beat_off;
      if (WRAP != 0)
         cur_idx = (start_idx & ~LMASK) | ((start_idx + beat_off) & LMASK);
   end

   assign cur_rdata = mem[cur_idx] ^ addr_pattern(cur_idx);

   always_ff @(posedge clk)
      if (!rst && state == WDATA && l2.L2wvalid)
         mem[cur_idx] <= l2.L2wdata ^ addr_pattern(cur_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         beat     <= '0;
         lat_cnt  <= '0;
         strobe_q <= 1'b0;
         data_q   <= '0;
      end else begin
         strobe_q <= 1'b0;
         data_q   <= '0;
         case (state)
            IDLE: begin
               if (l2.L2cmd_valid) begin
                  start_idx <= l2.L2addr[MEM_AW+B-1:B];
                  beat      <= '0;
                  lat_cnt   <= LAT_W'(READ_LAT - 1);
                  state     <= l2.L2cmd ? WDATA : RLAT;
               end
            end
            RLAT: begin
               if (lat_cnt == '0) begin
                  strobe_q <= 1'b1;
                  data_q   <= cur_rdata;
                  beat     <= beat + 1'b1;
                  state    <= RBURST;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            RBURST: begin
               if (beat == BEAT_END) begin
                  beat  <= '0;
                  state <= IDLE;
               end else begin
                  strobe_q <= 1'b1;
                  data_q   <= cur_rdata;
                  beat     <= beat + 1'b1;
               end
            end
            WDATA: begin
               if (l2.L2wvalid) begin
                  if (beat[L-1:0] == BEAT_LAST) begin
                     beat    <= '0;
                     lat_cnt <= LAT_W'(WRITE_LAT - 1);
                     state   <= WLAT;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            WLAT: begin
               if (lat_cnt == '0) begin
                  strobe_q <= 1'b1;
                  state    <= IDLE;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign l2.L2cmd_ready = (state == IDLE);
   assign l2.busy        = (state != IDLE);
   assign l2.strobe      = strobe_q;
   assign l2.L2data      = data_q;
endmodule

// File: tb/tb_dram_burst_model.sv
// Bench for dram_burst_model: linear and wrap instances driven in lockstep against a word-array model.
module tb_dram_burst_model;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 32;
   localparam int MEM_AW = 12;
   localparam int BL     = 8;
   localparam int RL     = 4;
   localparam int WL     = 2;
   localparam int DEPTH  = 1 << MEM_AW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd = 1'b0;
   logic              wvalid = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [DATA_W-1:0] wdata = '0;

   dram_burst_model_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
   dram_burst_model_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

   assign bus0.L2cmd_valid = cmd_valid;
   assign bus0.L2cmd       = cmd;
   assign bus0.L2addr      = addr;
   assign bus0.L2wdata     = wdata;
   assign bus0.L2wvalid    = wvalid;
   assign bus1.L2cmd_valid = cmd_valid;
   assign bus1.L2cmd       = cmd;
   assign bus1.L2addr      = addr;
   assign bus1.L2wdata     = wdata;
   assign bus1.L2wvalid    = wvalid;

   dram_burst_model #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .BURST_LEN(BL),
                      .READ_LAT(RL), .WRITE_LAT(WL), .WRAP(0))
      dut0 (.clk(clk), .rst(rst), .l2(bus0));
   dram_burst_model #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .BURST_LEN(BL),
                      .READ_LAT(RL), .WRITE_LAT(WL), .WRAP(1))
      dut1 (.clk(clk), .rst(rst), .l2(bus1));

   always #5 clk = ~clk;

   logic              obs_strobe [2];
   logic              obs_ready  [2];
   logic              obs_busy   [2];
   logic [DATA_W-1:0] obs_data   [2];
   assign obs_strobe[0] = bus0.strobe;
   assign obs_strobe[1] = bus1.strobe;
   assign obs_ready[0]  = bus0.L2cmd_ready;
   assign obs_ready[1]  = bus1.L2cmd_ready;
   assign obs_busy[0]   = bus0.busy;
   assign obs_busy[1]   = bus1.busy;
   assign obs_data[0]   = bus0.L2data;
   assign obs_data[1]   = bus1.L2data;

   int checks   = 0;
   int failures = 0;

   logic [DATA_W-1:0] mdl  [2][DEPTH];
   logic [DATA_W-1:0] cap  [2][BL];
   logic [DATA_W-1:0] wbuf [BL];

   typedef struct {
      logic [ADDR_W-1:0] a;
      int                w;
      logic [DATA_W-1:0] e0;
      logic [DATA_W-1:0] e1;
      logic [DATA_W-1:0] e7;
   } rvec_t;
   rvec_t tbl [6];

   task automatic chk(input string name, input int w, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s wrap=%0d actual=%h required=%h t=%0t", name, w, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int start_of(input logic [ADDR_W-1:0] a);
      return int'((a >> 3) % DEPTH);
   endfunction

   // Beat order straight from the ordering rules: linear modulo depth, or wrap inside the aligned block.
   function automatic int beat_idx(input int w, input int s, input int k);
      if (w == 0) return (s + k) % DEPTH;
      return (s / BL) * BL + ((s % BL) + k) % BL;
   endfunction

   task automatic issue(input logic c, input logic [ADDR_W-1:0] a, input bit hold);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd       = c;
      addr      = a;
      while (!(obs_ready[0] && obs_ready[1]) && n < 60) begin
         step();
         n++;
      end
      chk("accept_wait", 0, DATA_W'(n < 60), DATA_W'(1));
      step();
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic check_burst(input logic [ADDR_W-1:0] a, input int abort_at);
      int s;
      s = start_of(a);
      for (int c = 1; c < RL; c++) begin
         wvalid = 1'($urandom_range(0, 1));
         wdata  = {$urandom, $urandom};
         step();
         for (int w = 0; w < 2; w++) begin
            chk("rlat_strobe", w, DATA_W'(obs_strobe[w]), DATA_W'(0));
            chk("rlat_ready", w, DATA_W'(obs_ready[w]), DATA_W'(0));
         end
      end
      for (int k = 0; k < BL; k++) begin
         wvalid = 1'($urandom_range(0, 1));
         wdata  = {$urandom, $urandom};
         step();
         for (int w = 0; w < 2; w++) begin
            chk("beat_strobe", w, DATA_W'(obs_strobe[w]), DATA_W'(1));
            chk("beat_data", w, obs_data[w], mdl[w][beat_idx(w, s, k)]);
            chk("beat_busy", w, DATA_W'(obs_busy[w]), DATA_W'(1));
            cap[w][k] = obs_data[w];
         end
         if (k == abort_at) begin
            rst    = 1'b1;
            wvalid = 1'b0;
            step();
            rst = 1'b0;
            for (int w = 0; w < 2; w++) begin
               chk("abort_strobe", w, DATA_W'(obs_strobe[w]), DATA_W'(0));
               chk("abort_data", w, obs_data[w], DATA_W'(0));
               chk("abort_busy", w, DATA_W'(obs_busy[w]), DATA_W'(0));
               chk("abort_ready", w, DATA_W'(obs_ready[w]), DATA_W'(1));
            end
            return;
         end
      end
      wvalid = 1'b0;
      step();
      for (int w = 0; w < 2; w++) begin
         chk("end_strobe", w, DATA_W'(obs_strobe[w]), DATA_W'(0));
         chk("end_data", w, obs_data[w], DATA_W'(0));
         chk("end_ready", w, DATA_W'(obs_ready[w]), DATA_W'(1));
      end
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [BL-1:0] gaps);
      int s;
      s = start_of(a);
      issue(1'b1, a, 1'b0);
      for (int k = 0; k < BL; k++) begin
         if (gaps[k]) begin
            wvalid = 1'b0;
            wdata  = {$urandom, $urandom};
            step();
            for (int w = 0; w < 2; w++) begin
               chk("wgap_busy", w, DATA_W'(obs_busy[w]), DATA_W'(1));
               chk("wgap_strobe", w, DATA_W'(obs_strobe[w]), DATA_W'(0));
            end
         end
         wvalid = 1'b1;
         wdata  = wbuf[k];
         step();
         for (int w = 0; w < 2; w++) mdl[w][beat_idx(w, s, k)] = wbuf[k];
      end
      wvalid = 1'b0;
      for (int c = 0; c < WL; c++) begin
         for (int w = 0; w < 2; w++) begin
            chk("wlat_strobe", w, DATA_W'(obs_strobe[w]), DATA_W'(0));
            chk("wlat_busy", w, DATA_W'(obs_busy[w]), DATA_W'(1));
         end
         step();
      end
      for (int w = 0; w < 2; w++)
         chk("wdone_strobe", w, DATA_W'(obs_strobe[w]), DATA_W'(1));
      step();
      for (int w = 0; w < 2; w++) begin
         chk("wdone_pulse", w, DATA_W'(obs_strobe[w]), DATA_W'(0));
         chk("wdone_ready", w, DATA_W'(obs_ready[w]), DATA_W'(1));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [ADDR_W-1:0] ra;
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < DEPTH; i++) mdl[w][i] = DATA_W'(i * 8);

      tbl[0] = '{a: 32'h40,   w: 0, e0: 64'h40,   e1: 64'h48,   e7: 64'h78};
      tbl[1] = '{a: 32'h50,   w: 1, e0: 64'h50,   e1: 64'h58,   e7: 64'h48};
      tbl[2] = '{a: 32'h7FF8, w: 0, e0: 64'h7FF8, e1: 64'h0,    e7: 64'h30};
      tbl[3] = '{a: 32'h7FF8, w: 1, e0: 64'h7FF8, e1: 64'h7FC0, e7: 64'h7FF0};
      tbl[4] = '{a: 32'h8045, w: 0, e0: 64'h40,   e1: 64'h48,   e7: 64'h78};
      tbl[5] = '{a: 32'h5B,   w: 1, e0: 64'h58,   e1: 64'h60,   e7: 64'h50};

      rst = 1'b1;
      repeat (3) step();
      for (int w = 0; w < 2; w++) begin
         chk("rst_strobe", w, DATA_W'(obs_strobe[w]), DATA_W'(0));
         chk("rst_data", w, obs_data[w], DATA_W'(0));
         chk("rst_busy", w, DATA_W'(obs_busy[w]), DATA_W'(0));
         chk("rst_ready", w, DATA_W'(obs_ready[w]), DATA_W'(1));
      end
      rst = 1'b0;
      step();

      // Untouched-memory reads with hand-computed beats.
      for (int i = 0; i < 6; i++) begin
         issue(1'b0, tbl[i].a, 1'b0);
         check_burst(tbl[i].a, -1);
         chk("tbl_beat0", tbl[i].w, cap[tbl[i].w][0], tbl[i].e0);
         chk("tbl_beat1", tbl[i].w, cap[tbl[i].w][1], tbl[i].e1);
         chk("tbl_beat7", tbl[i].w, cap[tbl[i].w][7], tbl[i].e7);
      end

      // Writeback with gaps, then read back.
      for (int k = 0; k < BL; k++) wbuf[k] = DATA_W'(8'hA0 + k);
      do_write(32'h100, 8'b0010_0100);
      issue(1'b0, 32'h100, 1'b0);
      check_burst(32'h100, -1);
      for (int w = 0; w < 2; w++)
         for (int k = 0; k < BL; k++)
            chk("wb_readback", w, cap[w][k], DATA_W'(8'hA0 + k));

      // Second command held valid through a burst.
      issue(1'b0, 32'h40, 1'b1);
      addr = 32'h200;
      check_burst(32'h40, -1);
      issue(1'b0, 32'h200, 1'b0);
      check_burst(32'h200, -1);

      // Reset during beat 3, then the same address again.
      issue(1'b0, 32'h40, 1'b0);
      check_burst(32'h40, 3);
      issue(1'b0, 32'h40, 1'b0);
      check_burst(32'h40, -1);
      chk("reread_beat0", 0, cap[0][0], DATA_W'(64'h40));
      chk("reread_beat7", 0, cap[0][7], DATA_W'(64'h78));

      for (int i = 0; i < 40; i++) begin
         ra = $urandom & 32'hFFFF_83FF;
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < BL; k++) wbuf[k] = {$urandom, $urandom};
            do_write(ra, 8'($urandom));
         end else begin
            wvalid = 1'b1;
            wdata  = {$urandom, $urandom};
            issue(1'b0, ra, 1'b0);
            check_burst(ra, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, BL - 1)) : -1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
